// File: rtl/windowed_majority_voter.sv
// rtl/windowed_majority_voter.sv - multi-channel sliding-window majority voter
// All channels share one fill counter; each keeps its own bit history and ones-count.
module windowed_majority_voter #(
    parameter int CHANNELS = 4,
    parameter int WINDOW   = 7,
    parameter int TIE_ONE  = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clear,
    input  logic                                    in_valid,
    input  logic [CHANNELS-1:0]                     in_data,
    output logic                                    out_valid,
    output logic [CHANNELS-1:0]                     out_major,
    output logic [CHANNELS*$clog2(WINDOW+1)-1:0]    out_count,
    output logic [$clog2(WINDOW+1)-1:0]             fill_level,
    output logic                                    window_full
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WIN = CW'(WINDOW);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_FILLING = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       fill_q, fill_d;
    logic [WINDOW-1:0]   hist_q [CHANNELS];
    logic [WINDOW-1:0]   hist_d [CHANNELS];
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] major_q, major_d;
    logic                valid_q;

    // Doubling in CW+1 bits keeps 2*count from wrapping when count == WINDOW.
    function automatic logic vote(input logic [CW-1:0] c, input logic [CW-1:0] f);
        logic [CW:0] c2;
        logic [CW:0] f1;
        c2 = {c, 1'b0};
        f1 = {1'b0, f};
        return (c2 > f1) || ((TIE_ONE != 0) && (c2 == f1));
    endfunction

    logic                base_full;
    logic [CW-1:0]       base_fill;
    logic [WINDOW-1:0]   base_hist;
    logic [CW-1:0]       base_cnt;
    logic                oldest;

    always_comb begin
        base_full = !clear && (state_q == S_FULL);
        base_fill = clear ? '0 : fill_q;
        base_hist = '0;
        base_cnt  = '0;
        oldest    = 1'b0;

        if (in_valid) begin
            fill_d = base_full ? WIN : base_fill + CW'(1);
        end else begin
            fill_d = base_fill;
        end

        if (fill_d == '0) begin
            state_d = S_EMPTY;
        end else if (fill_d == WIN) begin
            state_d = S_FULL;
        end else begin
            state_d = S_FILLING;
        end

        for (int ch = 0; ch < CHANNELS; ch++) begin
            base_hist = clear ? '0 : hist_q[ch];
            base_cnt  = clear ? '0 : cnt_q[ch];
            oldest    = base_full & base_hist[WINDOW-1];
            if (in_valid) begin
                hist_d[ch]    = base_hist << 1;
                hist_d[ch][0] = in_data[ch];
                cnt_d[ch]     = base_cnt + CW'(in_data[ch]) - CW'(oldest);
                major_d[ch]   = vote(cnt_d[ch], fill_d);
            end else begin
                hist_d[ch]    = base_hist;
                cnt_d[ch]     = base_cnt;
                major_d[ch]   = clear ? 1'b0 : major_q[ch];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            fill_q  <= '0;
            major_q <= '0;
            valid_q <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hist_q[ch] <= '0;
                cnt_q[ch]  <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            major_q <= major_d;
            valid_q <= in_valid;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hist_q[ch] <= hist_d[ch];
                cnt_q[ch]  <= cnt_d[ch];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign out_count[g*CW +: CW] = cnt_q[g];
    end

    assign out_valid   = valid_q;
    assign out_major   = major_q;
    assign fill_level  = fill_q;
    assign window_full = (state_q == S_FULL);

endmodule

// File: tb/tb_windowed_majority_voter.sv
// tb/tb_windowed_majority_voter.sv - scoreboard bench driving a W=7/tie-1 and a W=4/tie-0 voter
// Both instances see the same stream; the reference keeps raw sample history and recounts.
module tb_windowed_majority_voter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;

    always #5 clk = ~clk;

    logic        ov [2];
    logic [3:0]  om [2];
    logic [11:0] oc [2];
    logic [2:0]  fl [2];
    logic        wf [2];

    windowed_majority_voter #(.CHANNELS(4), .WINDOW(7), .TIE_ONE(1)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_major(om[0]), .out_count(oc[0]),
        .fill_level(fl[0]), .window_full(wf[0])
    );

    windowed_majority_voter #(.CHANNELS(4), .WINDOW(4), .TIE_ONE(0)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_major(om[1]), .out_count(oc[1]),
        .fill_level(fl[1]), .window_full(wf[1])
    );

    typedef struct packed {
        logic [3:0]  major;
        logic [11:0] count;
        logic [2:0]  fill;
        logic        full;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t      sbq [$];
    logic [3:0] hist [$];
    int         n_since = 0;
    exp_t       last [2];
    int         zchk = 0;
    bit         hold_ok = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    function automatic exp_t model(input int w, input bit tie);
        exp_t e;
        int f;
        int c;
        e = '0;
        f = (n_since < w) ? n_since : w;
        e.fill = 3'(f);
        e.full = (f == w);
        for (int ch = 0; ch < 4; ch++) begin
            c = 0;
            for (int j = 0; j < f; j++) c += int'(hist[hist.size() - 1 - j][ch]);
            e.count[ch*3 +: 3] = 3'(c);
            e.major[ch] = (2 * c > f) || (tie && (2 * c == f));
        end
        return e;
    endfunction

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input int k, input exp_t e, input string tag);
        chk({tag, "_major"}, k, int'(om[k]), int'(e.major));
        chk({tag, "_count"}, k, int'(oc[k]), int'(e.count));
        chk({tag, "_fill"},  k, int'(fl[k]), int'(e.fill));
        chk({tag, "_full"},  k, int'(wf[k]), int'(e.full));
    endtask

    always @(negedge clk) begin
        pair_t p;
        if (ov[0] || ov[1]) begin
            chk("out_valid_a", 0, int'(ov[0]), 1);
            chk("out_valid_b", 1, int'(ov[1]), 1);
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 0, 1, 0);
            end else begin
                p = sbq.pop_front();
                last[0] = p.a;
                last[1] = p.b;
                cmp_out(0, p.a, "sample");
                cmp_out(1, p.b, "sample");
                hold_ok = 1'b1;
            end
        end else if (zchk == 1) begin
            last[0] = '0;
            last[1] = '0;
            cmp_out(0, last[0], "flushed");
            cmp_out(1, last[1], "flushed");
            hold_ok = 1'b1;
        end else if (hold_ok) begin
            cmp_out(0, last[0], "hold");
            cmp_out(1, last[1], "hold");
        end
        if (zchk > 0) zchk--;
        if (sbq.size() > 1) begin
            chk("missing_out_valid", 0, sbq.size(), 1);
            void'(sbq.pop_front());
        end
    end

    task automatic step(input bit r, input bit v, input bit c, input logic [3:0] d);
        pair_t p;
        @(posedge clk);
        #1;
        rst      = r;
        clear    = c;
        in_valid = v;
        in_data  = v ? d : 4'($urandom);
        if (r || (c && !v)) begin
            hist.delete();
            n_since = 0;
            zchk    = 2;
            hold_ok = 1'b0;
        end else if (v) begin
            if (c) begin
                hist.delete();
                n_since = 0;
            end
            hist.push_back(d);
            if (hist.size() > 7) void'(hist.pop_front());
            n_since++;
            p.a = model(7, 1'b1);
            p.b = model(4, 1'b0);
            sbq.push_back(p);
        end
    endtask

    logic [3:0] seq0 [8] = '{4'b0111, 4'b0110, 4'b0010, 4'b0010,
                             4'b0100, 4'b0000, 4'b0000, 4'b0000};

    initial begin
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        // ch0 1,0,0 / ch1 1111000 then 0 / ch2 1,1,0,0 then 1
        foreach (seq0[i]) step(0, 1, 0, seq0[i]);
        step(0, 1, 0, 4'b1011);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 1, 0, 4'b0101);
        step(0, 1, 1, 4'b1010);
        step(0, 0, 1, '0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 4'($urandom));
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 150) == 0, ($urandom % 4) != 0, ($urandom % 25) == 0, 4'($urandom));
        end
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        @(negedge clk);
        chk("scoreboard_drained", 0, sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
